// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - shared register map constants for the UART receive buffer
//
// Purpose: register word addresses and bit positions used by uart_rx_buffer
// and by anything that decodes its register window.
package uart_rx_buffer_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_CNT_LSB = 8;
    localparam int CTRL_IEN   = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int DATA_VALID = 8;

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// rtl/uart_rx_buffer_sync_fifo.sv - single-clock byte FIFO with flush
//
// Purpose: DEPTH-entry byte FIFO with show-ahead head output.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, din       write request and byte; ignored when full unless popping
//   pop             read request; ignored when empty
//   flush           clears pointers and count; overrides push and pop
//   dout            byte at the head (valid only when !empty)
//   count           fill level 0..DEPTH
//   full, empty     fill level flags
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push into a full FIFO
    // is still accepted when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive byte buffer with Avalon-MM register window
//
// Purpose: captures each received byte into a FIFO and exposes data, status
// and control registers to the CPU, with sticky overrun and level interrupt.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rx_data, rx_done           received byte and completion strobe (edge-detected)
//   avs_address                register word address
//   avs_read, avs_readdata     read strobe, registered read data (1-cycle latency)
//   avs_write, avs_writedata   write strobe and data
//   irq                        registered level interrupt
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic        rx_done_q;
    logic        overrun_q, overrun_d;
    logic        ien_q, ien_d;
    logic        irq_q, irq_d;
    logic [31:0] readdata_q, readdata_d;

    logic        push_edge, pop, flush, fifo_push;
    logic        accept_push;
    logic [7:0]  head;
    logic [AW:0] count, count_next;
    logic        full, empty;

    // rx_done may stay high for several cycles; only its rising edge counts.
    assign push_edge = rx_done & ~rx_done_q;
    assign pop       = avs_read & (avs_address == ADDR_DATA) & ~empty;
    assign flush     = avs_write & (avs_address == ADDR_CTRL) & avs_writedata[CTRL_FLUSH];
    assign fifo_push = push_edge & ~flush;
    assign accept_push = fifo_push & (~full | pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (rx_data),
        .pop   (pop),
        .flush (flush),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Fill level after this edge, so irq reflects the post-update state.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({accept_push, pop})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (avs_write && avs_address == ADDR_STATUS && avs_writedata[ST_OVR])
            overrun_d = 1'b0;
        // Set is evaluated last so it wins over a simultaneous clear.
        // A byte dropped by a flush is not an overrun.
        if (fifo_push && full && !pop)
            overrun_d = 1'b1;

        ien_d = ien_q;
        if (avs_write && avs_address == ADDR_CTRL)
            ien_d = avs_writedata[CTRL_IEN];

        irq_d = ien_d & ((count_next != '0) | overrun_d);
    end

    // Read mux uses pre-edge state: a pop in this cycle returns the old head.
    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = '0;
            case (avs_address)
                ADDR_DATA: begin
                    if (!empty) begin
                        readdata_d[7:0]        = head;
                        readdata_d[DATA_VALID] = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    readdata_d[ST_NEMPTY]           = ~empty;
                    readdata_d[ST_FULL]             = full;
                    readdata_d[ST_OVR]              = overrun_q;
                    readdata_d[ST_CNT_LSB +: 8]     = 8'(count);
                end
                ADDR_CTRL: begin
                    readdata_d[CTRL_IEN]            = ien_q;
                end
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ien_q      <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            rx_done_q  <= rx_done;
            overrun_q  <= overrun_d;
            ien_q      <= ien_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule
